// File: rtl/cache_nway.sv
// cache_nway -- N-way set-associative, write-back, write-allocate line cache
// with a tree pseudo-LRU replacement policy and an embedded control FSM.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   mem_read/mem_write   CPU request, held until mem_resp (both high = write)
//   mem_address          CPU byte address
//   mem_wdata            CPU write line, merged under mem_byte_enable256
//   mem_rdata/mem_resp   read line and one-cycle completion pulse
//   pmem_read/pmem_write line fill / writeback request, held until pmem_resp
//   pmem_address         line-aligned memory address
//   pmem_wdata           writeback line
//   pmem_rdata/pmem_resp fill data and memory completion
//   dbg_state            current controller state (CHECK=0, WRITEBACK=1, FILL=2)
//   hit_count/miss_count only when CACHE_PERF_COUNTERS_EN is defined
//
// Handshake: a CPU request is accepted when mem_read or mem_write is seen
// high in CHECK; it must stay stable until the cycle mem_resp is high and is
// dropped the cycle after. pmem_read/pmem_write stay high until the memory
// returns pmem_resp for one cycle; at most one of them is ever high.
//
// Optional feature macro: CACHE_PERF_COUNTERS_EN adds hit/miss counters.
module cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   dbg_state
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int NSETS = 2 ** s_index;
    localparam int TW    = 32 - s_offset - s_index;
    localparam int WAYB  = $clog2(num_ways);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [WAYB-1:0] victim_q, victim_d;

    logic           valid_q [NSETS][num_ways];
    logic           valid_d [NSETS][num_ways];
    logic           dirty_q [NSETS][num_ways];
    logic           dirty_d [NSETS][num_ways];
    logic [TW-1:0]  tag_q   [NSETS][num_ways];
    logic [TW-1:0]  tag_d   [NSETS][num_ways];
    logic [255:0]   data_q  [NSETS][num_ways];
    logic [255:0]   data_d  [NSETS][num_ways];
    logic [num_ways-2:0] plru_q [NSETS];
    logic [num_ways-2:0] plru_d [NSETS];

    logic [s_index-1:0] set;
    logic [TW-1:0]      req_tag;
    logic               req;
    logic               hit;
    logic [WAYB-1:0]    hit_way;
    logic [WAYB-1:0]    pick_way;
    logic               have_invalid;
    logic [255:0]       line_tmp;
    logic               unused_addr_bits;

    assign set              = mem_address[s_offset+s_index-1:s_offset];
    assign req_tag          = mem_address[31:s_offset+s_index];
    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^mem_address[s_offset-1:0];
    assign dbg_state        = state_q;

    // Walk the tree from the root; each node bit selects the half holding
    // the victim (0 = lower, 1 = upper). Nodes use heap numbering.
    function automatic logic [WAYB-1:0] plru_victim(input logic [num_ways-2:0] t);
        logic [WAYB-1:0] v;
        logic [WAYB-1:0] node;
        v    = '0;
        node = '0;
        for (int l = WAYB - 1; l >= 0; l--) begin
            v[l] = t[node];
            node = WAYB'(2 * int'(node) + 1 + int'(t[node]));
        end
        return v;
    endfunction

    // Every node on the accessed way's path is turned to point away from it.
    function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] t,
                                                       input logic [WAYB-1:0] w);
        logic [num_ways-2:0] r;
        logic [WAYB-1:0]     node;
        r    = t;
        node = '0;
        for (int l = WAYB - 1; l >= 0; l--) begin
            r[node] = ~w[l];
            node    = WAYB'(2 * int'(node) + 1 + int'(w[l]));
        end
        return r;
    endfunction

    // Tag lookup and victim choice: the lowest-index invalid way wins,
    // otherwise the PLRU tree decides.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        have_invalid = 1'b0;
        pick_way     = plru_victim(plru_q[set]);
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid_q[set][w] && tag_q[set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAYB'(w);
            end
            if (!valid_q[set][w]) begin
                have_invalid = 1'b1;
                pick_way     = WAYB'(w);
            end
        end
        if (!have_invalid) begin
            pick_way = plru_victim(plru_q[set]);
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        plru_d       = plru_q;
        line_tmp     = '0;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp     = 1'b1;
                        mem_rdata    = data_q[set][hit_way];
                        plru_d[set]  = plru_touch(plru_q[set], hit_way);
                        if (mem_write) begin
                            line_tmp = data_q[set][hit_way];
                            for (int b = 0; b < 32; b++) begin
                                if (mem_byte_enable256[b]) begin
                                    line_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
                                end
                            end
                            data_d[set][hit_way]  = line_tmp;
                            dirty_d[set][hit_way] = 1'b1;
                        end
                    end else begin
                        victim_d = pick_way;
                        if (valid_q[set][pick_way] && dirty_q[set][pick_way]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[set][victim_q], set, {s_offset{1'b0}}};
                pmem_wdata   = data_q[set][victim_q];
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, set, {s_offset{1'b0}}};
                if (pmem_resp) begin
                    data_d[set][victim_q]  = pmem_rdata;
                    tag_d[set][victim_q]   = req_tag;
                    valid_d[set][victim_q] = 1'b1;
                    dirty_d[set][victim_q] = 1'b0;
                    state_d                = CHECK;
                end
            end
            default: begin
                state_d = CHECK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CHECK;
            victim_q <= '0;
            for (int s = 0; s < NSETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < num_ways; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            plru_q   <= plru_d;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    // The hit that completes a miss is flagged by post_fill_q so that each
    // request counts exactly once, as either a hit or a miss.
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        post_fill_q, post_fill_d;
    logic        check_hit, check_miss;

    assign check_hit  = (state_q == CHECK) && req && hit && !post_fill_q;
    assign check_miss = (state_q == CHECK) && req && !hit;

    always_comb begin
        hit_count_d  = hit_count_q + 32'(check_hit);
        miss_count_d = miss_count_q + 32'(check_miss);
        post_fill_d  = (state_q == FILL) && pmem_resp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            post_fill_q  <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            post_fill_q  <= post_fill_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway -- directed bench for cache_nway. A reference view of memory
// (ref_mem) tracks what the CPU should read; a backing store (bmem) models
// the next level. Expected read lines are queued when a request is driven and
// popped when mem_resp appears.
module tb_cache_nway;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   dbg_state;
`ifdef CACHE_PERF_COUNTERS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_nway dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_rdata          (mem_rdata),
        .mem_resp           (mem_resp),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_address       (pmem_address),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp),
        .dbg_state          (dbg_state)
`ifdef CACHE_PERF_COUNTERS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [255:0] exp_q[$];
    logic [255:0] bmem [logic [31:0]];
    logic [255:0] ref_mem [logic [31:0]];
    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    function automatic logic [255:0] dflt(input logic [31:0] a);
        if (a == 32'h40) return {32{8'hA5}};
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function logic [255:0] bline(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : dflt(a);
    endfunction

    function logic [255:0] rline(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one CPU request (starting at a falling edge) and plays the
    // memory side with a fixed latency until mem_resp.
    task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [255:0] wd, input logic [31:0] be,
                          input bit exp_hit, input bit exp_wb, input logic [31:0] wb_addr);
        logic [31:0]  line_a;
        logic [255:0] l;
        logic [255:0] got;
        int cycles, lat, resp_cyc;
        bit done, saw_wb, saw_fill;
        line_a = {addr[31:5], 5'b0};
        exp_q.push_back(rline(line_a));
        if (wr) begin
            l = rline(line_a);
            for (int b = 0; b < 32; b++) if (be[b]) l[8*b +: 8] = wd[8*b +: 8];
            ref_mem[line_a] = l;
        end
        if (exp_hit) exp_hits++; else exp_miss++;
        mem_address        = addr;
        mem_read           = !wr;
        mem_write          = wr;
        mem_wdata          = wd;
        mem_byte_enable256 = be;
        cycles = 0; lat = 0; resp_cyc = -10;
        done = 0; saw_wb = 0; saw_fill = 0;
        while (!done && cycles < 200) begin
            #1;
            chk({tag, " rd_wr_excl"}, 256'(pmem_read & pmem_write), 256'(0));
            if (pmem_write && !saw_wb) begin
                saw_wb = 1;
                chk({tag, " wb_addr"}, 256'(pmem_address), 256'(wb_addr));
                chk({tag, " wb_data"}, pmem_wdata, rline(wb_addr));
            end
            if (pmem_read && !saw_fill) begin
                saw_fill = 1;
                chk({tag, " fill_addr"}, 256'(pmem_address), 256'(line_a));
            end
            if (mem_resp) begin
                done = 1;
                got  = exp_q.pop_front();
                chk({tag, " rdata"}, mem_rdata, got);
                if (exp_hit) chk({tag, " hit_lat"}, 256'(cycles), 256'(0));
                else         chk({tag, " miss_lat"}, 256'(cycles), 256'(resp_cyc + 1));
                chk({tag, " saw_wb"}, 256'(saw_wb), 256'(exp_wb));
                chk({tag, " saw_fill"}, 256'(saw_fill), 256'(!exp_hit));
            end
            if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                lat++;
                if (lat == 3) begin
                    lat = 0;
                    if (pmem_write) bmem[pmem_address] = pmem_wdata;
                    pmem_rdata = bline(pmem_address);
                    pmem_resp  = 1'b1;
                    resp_cyc   = cycles;
                end
            end
            if (!done) begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!done) chk({tag, " timeout"}, 256'(1), 256'(0));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " idle_resp"}, 256'(mem_resp), 256'(0));
        chk({tag, " idle_pmem"}, 256'({pmem_read, pmem_write}), 256'(0));
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input bit exp_hit,
                      input bit exp_wb, input logic [31:0] wb_addr);
        access(tag, addr, 1'b0, '0, '0, exp_hit, exp_wb, wb_addr);
    endtask

    initial begin
        logic [255:0] rnd_line;
        logic [31:0]  rnd_be;
        int guard;
        rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = '0;
        mem_wdata = '0; mem_byte_enable256 = '0; pmem_rdata = '0; pmem_resp = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_resp", 256'(mem_resp), 256'(0));
        chk("reset pmem_read", 256'(pmem_read), 256'(0));
        chk("reset pmem_write", 256'(pmem_write), 256'(0));
        chk("reset pmem_address", 256'(pmem_address), 256'(0));
        chk("reset state", 256'(dbg_state), 256'(0));
`ifdef CACHE_PERF_COUNTERS_EN
        chk("reset hit_count", 256'(hit_count), 256'(0));
        chk("reset miss_count", 256'(miss_count), 256'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss then rehit
        rd("rd40_miss", 32'h40, 0, 0, 0);
        rd("rd40_hit", 32'h40, 1, 0, 0);

        // Fill set 0 in way order, touch way 0, then a miss evicts way 2
        rd("fill000", 32'h000, 0, 0, 0);
        rd("fill100", 32'h100, 0, 0, 0);
        rd("fill200", 32'h200, 0, 0, 0);
        rd("fill300", 32'h300, 0, 0, 0);
        rd("hit000", 32'h000, 1, 0, 0);
        rd("miss400", 32'h400, 0, 0, 0);
        rd("miss200", 32'h200, 0, 0, 0);

        // Partial write to 0x000, steer PLRU to way 0, evict it dirty
        access("wr000", 32'h000, 1'b1, {{7{32'h1234_5678}}, 32'hDEAD_BEEF},
               32'h0000_000F, 1, 0, 0);
        rd("hit200", 32'h200, 1, 0, 0);
        rd("hit400", 32'h400, 1, 0, 0);
        rd("miss600_wb", 32'h600, 0, 1, 32'h000);
        chk("bmem 000 low word", 256'(bline(32'h000) & 256'hFFFF_FFFF), 256'(32'hDEAD_BEEF));

        // Reset while a fill is outstanding
        mem_address = 32'h800; mem_read = 1'b1;
        guard = 0;
        while (!pmem_read && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_fill pmem_read seen", 256'(pmem_read), 256'(1));
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_fill pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_fill pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_fill pmem_address", 256'(pmem_address), 256'(0));
        chk("rst_fill state", 256'(dbg_state), 256'(0));
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd("rd40_after_rst", 32'h40, 0, 0, 0);

        // Random byte-enable merge on a resident line
        for (int i = 0; i < 8; i++) rnd_line[32*i +: 32] = $urandom;
        rnd_be = $urandom_range(32'hFFFF_FFFE, 1);
        access("wr40_rnd", 32'h40, 1'b1, rnd_line, rnd_be, 1, 0, 0);
        rd("rd40_merged", 32'h40, 1, 0, 0);
        access("rdwr40", 32'h40, 1'b1, ~rnd_line, 32'hFFFF_FFFF, 1, 0, 0);
        mem_read = 1'b0;
        rd("rd40_full", 32'h40, 1, 0, 0);

        chk("exp_q empty", 256'(exp_q.size()), 256'(0));
`ifdef CACHE_PERF_COUNTERS_EN
        chk("hit_count", 256'(hit_count), 256'(exp_hits));
        chk("miss_count", 256'(miss_count), 256'(exp_miss));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst hit_count", 256'(hit_count), 256'(0));
        chk("rst miss_count", 256'(miss_count), 256'(0));
        rst = 1'b0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache with a tree pseudo-LRU replacement policy and its own control FSM. It generalises the two-way datapath to any power-of-two way count, folds in the controller, and adds byte-enable merging and first-invalid-way victim selection. It sits between a CPU-side 256-bit line port and the physical memory / next-level port.

## Interface
- s_offset, 5, line offset bits (line = 2**s_offset bytes; 256 bits at default)
- s_index, 3, set index bits (1..8)
- num_ways, 4, associativity (power of two, 2..16)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  32  byte address; tag=[31:s_offset+s_index], set=[s_offset+s_index-1:s_offset]
- mem_wdata  in  256  write line data
- mem_byte_enable256  in  32  per-byte write enable
- mem_rdata  out  256  read line data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line-aligned address (low s_offset bits 0)
- pmem_wdata  out  256  writeback data
- pmem_rdata  in  256  fill data, sampled when pmem_resp=1
- pmem_resp  in  1  memory completion

## Operation
- Per way per set: valid, dirty, tag, 256-bit line; per set: num_ways-1 PLRU bits. Arrays are flop-based, asynchronous read.
- States: CHECK, WRITEBACK, FILL. Reset → CHECK; all valid, dirty, PLRU bits cleared.
- CHECK, no request: idle, all outputs 0.
- CHECK, hit: mem_resp=1 and mem_rdata=hit way line combinationally; on the edge, PLRU updated; on write, bytes with enable set replaced from mem_wdata, dirty=1.
- CHECK, miss: victim = lowest-index invalid way, else PLRU victim; latched in a victim register. Victim valid and dirty → WRITEBACK, else → FILL.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, set, 0}, pmem_wdata=victim line; on pmem_resp → FILL.
- FILL: pmem_read=1, pmem_address={request tag, set, 0}; on pmem_resp victim line←pmem_rdata, tag written, valid=1, dirty=0 → CHECK (request now hits; PLRU updated on that hit only).
- PLRU: node bit 0 = victim in lower half, 1 = upper half; on access to way w every node on w's path is set to point away from w.
- mem_read and mem_write both high: treated as write.
- Request signals must stay stable until mem_resp; changing them mid-miss is illegal.

## Timing
- Reset values: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, state CHECK.
- Hit: mem_resp in the first cycle the request is present (0-cycle added latency).
- Clean miss: FILL cycles (until pmem_resp) + 1 CHECK cycle. Dirty miss: WRITEBACK + FILL + 1.
- mem_resp never high for two consecutive cycles for one request; a new request may start the cycle after mem_resp.
- pmem_read and pmem_write never high together.
- Reset mid-WRITEBACK/FILL: abandoned; next cycle all outputs 0, arrays cleared; memory must tolerate a dropped request.

## Configuration
- CACHE_PERF_COUNTERS_EN defined: adds outputs hit_count[31:0], miss_count[31:0]; +1 on each CHECK-state hit (excluding post-fill hit) / each miss entry; cleared by rst; wrap at 2**32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, read 0x0000_0040 → pmem_read with pmem_address=0x40, no pmem_write; return line 0xA5…A5 → mem_resp with mem_rdata=0xA5…A5 one cycle after pmem_resp.
- Reread 0x0000_0040 → mem_resp same cycle, no pmem activity.
- Fill set 0 with 0x000,0x100,0x200,0x300, read 0x000, read 0x400 → victim 0x200 (way 2): no writeback, pmem_address=0x400; then read 0x200 → miss.
- Write 0x000 with byte_enable=0x0000000F, wdata=0x…DEADBEEF → hit; force its eviction → pmem_write at 0x000, pmem_wdata low 32 bits 0xDEADBEEF, upper bytes original, followed by FILL.
- Assert rst during FILL → pmem_read=0 next cycle; read of prior hit address then misses.
- CACHE_PERF_COUNTERS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2; rst → both 0.
